alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  - 32-bit integer ALU for the single-cycle/multicycle datapath execute stage.
//  - Operation is selected by a one-hot 4-bit opcode.
//  - Produces a registered 32-bit result and registered Neg/Zero/Overflow status flags.
//  - Consumed by writeback and by branch-decision logic (beq via Zero).
// PARAMETERS
//  - WIDTH  32  data-path width of A, B, ALUOut (the flag logic must hold for any WIDTH>=2)
// PORTS
//  - clk       in   1      single clock; all state updates on rising edge
//  - rst_n     in   1      reset: synchronous, active-low
//  - op        in   4      one-hot operation select
//  - A         in   WIDTH  operand A (two's complement)
//  - B         in   WIDTH  operand B (two's complement)
//  - ALUOut    out  WIDTH  registered result
//  - Neg       out  1      registered: ALUOut[WIDTH-1]
//  - Zero      out  1      registered: ALUOut == 0
//  - Overflow  out  1      registered: signed overflow of ADD/SUB
// BEHAVIOUR
//  - Opcodes (one-hot):
//      - 4'b0001 ADD: A+B
//      - 4'b0010 SUB: A-B
//      - 4'b0100 AND: A&B
//      - 4'b1000 OR:  A|B
//  - Any other op (0000 or more than one bit set) is illegal: result = 0, Overflow = 0.
//  - Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on outputs after edge N.
//      - No handshake; a new op is accepted every cycle.
//  - Arithmetic is modulo 2^WIDTH; the carry-out is discarded.
//  - SUB is implemented as A + ~B + 1 on the same adder as ADD.
//  - Overflow:
//      - ADD: (A[msb]==B[msb]) && (R[msb]!=A[msb])
//      - SUB: (A[msb]!=B[msb]) && (R[msb]!=A[msb])
//      - Forced 0 for AND, OR and illegal ops.
//  - Neg and Zero are derived from the same result value that is loaded into ALUOut, in the same cycle.
//  - Reset: when rst_n==0 at a rising edge:
//      - ALUOut=0, Neg=0, Overflow=0, Zero=1 (consistent with a zero result).
//      - Reset takes priority over any op.
//      - No asynchronous path; outputs hold until the edge.
//  - Outputs hold their last value only until the next edge; there is no enable, so the register reloads every cycle.
//  - Boundaries:
//      - 0x7FFFFFFF+1 = 0x80000000: Overflow=1, Neg=1.
//      - 0x80000000-1 = 0x7FFFFFFF: Overflow=1.
//      - 0xFFFFFFFF+1 = 0: Zero=1, Overflow=0.
// STRUCTURE
//  - Shared package alu_pkg:
//      - localparams ALU_ADD=4'b0001, ALU_SUB=4'b0010, ALU_AND=4'b0100, ALU_OR=4'b1000
//      - ALU_OP_W=4
//  - One natural sub-module, alu_addsub: combinational WIDTH-bit adder with invert-B/carry-in for SUB.
//      - Outputs sum and overflow.
//  - Top level contains:
//      - the op mux (case on one-hot op, default 0)
//      - flag derivation
//      - a single output register stage with synchronous active-low reset
// TESTING
//  - Reset: hold rst_n=0 for 2 edges -> ALUOut=0, Zero=1, Neg=0, Overflow=0.
//  - ADD: op=0001, A=1, B=1 -> after 1 edge ALUOut=0x00000002, Zero=0, Neg=0, Overflow=0.
//  - SUB: op=0010, A=5, B=7 -> ALUOut=0xFFFFFFFE, Neg=1, Overflow=0.
//      - Then A=B=0x1234 -> ALUOut=0, Zero=1.
//  - AND/OR: A=0xF0F0F0F0, B=0xFF00FF00.
//      - op=0100 -> ALUOut=0xF000F000.
//      - op=1000 -> ALUOut=0xFFF0FFF0, Neg=1.
//  - Overflow: op=0001, A=0x7FFFFFFF, B=1 -> ALUOut=0x80000000, Overflow=1.
//      - op=0010, A=0x80000000, B=1 -> ALUOut=0x7FFFFFFF, Overflow=1.
//  - Illegal op / latency: op=0011 -> ALUOut=0, Zero=1, Overflow=0.
//      - Change inputs every cycle; check each result lags its inputs by exactly one edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings for the execute-stage ALU.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b1000;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
interface alu_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic [ALU_OP_W-1:0] op;
    logic [WIDTH-1:0]    A;
    logic [WIDTH-1:0]    B;
    logic [WIDTH-1:0]    ALUOut;
    logic                Neg;
    logic                Zero;
    logic                Overflow;

    modport master (
        output op, A, B,
        input  ALUOut, Neg, Zero, Overflow
    );

    modport slave (
        input  op, A, B,
        output ALUOut, Neg, Zero, Overflow
    );

endinterface

// File: rtl/alu_addsub.sv
// Shared adder for ADD and SUB; SUB computes a + ~b + 1 with carry-out dropped.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
        // Comparing against the effective operand covers both the ADD and SUB overflow rules.
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// 32-bit one-hot-opcode ALU with a single registered result/flag stage.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] as_sum;
    logic             as_ovf;
    logic             as_sub;

    logic [WIDTH-1:0] alu_out_d, alu_out_q;
    logic             neg_d, neg_q;
    logic             zero_d, zero_q;
    logic             ovf_d, ovf_q;

    assign as_sub = (bus.op == ALU_SUB);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (bus.A),
        .b   (bus.B),
        .sub (as_sub),
        .sum (as_sum),
        .ovf (as_ovf)
    );

    always_comb begin
        alu_out_d = '0;
        ovf_d     = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                alu_out_d = as_sum;
                ovf_d     = as_ovf;
            end
            ALU_SUB: begin
                alu_out_d = as_sum;
                ovf_d     = as_ovf;
            end
            ALU_AND: alu_out_d = bus.A & bus.B;
            ALU_OR:  alu_out_d = bus.A | bus.B;
            default: begin
                alu_out_d = '0;
                ovf_d     = 1'b0;
            end
        endcase
        neg_d  = alu_out_d[WIDTH-1];
        zero_d = (alu_out_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            neg_q     <= neg_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.ALUOut   = alu_out_q;
    assign bus.Neg      = neg_q;
    assign bus.Zero     = zero_q;
    assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Directed plus randomized check of the ALU against a signed-arithmetic reference model.
module tb_alu;

    typedef struct packed {
        logic [31:0] res;
        logic        neg;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t prev_exp;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.res = 32'd0;
        e.ovf = 1'b0;
        if (op == 4'b0001) begin
            r     = sa + sb;
            e.res = r[31:0];
            e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end else if (op == 4'b0010) begin
            r     = sa - sb;
            e.res = r[31:0];
            e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end else if (op == 4'b0100) begin
            e.res = a & b;
        end else if (op == 4'b1000) begin
            e.res = a | b;
        end
        e.neg  = e.res[31];
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag, exp_t e);
        chk({tag, ".ALUOut"},   bus.ALUOut,          e.res);
        chk({tag, ".Neg"},      {31'd0, bus.Neg},      {31'd0, e.neg});
        chk({tag, ".Zero"},     {31'd0, bus.Zero},     {31'd0, e.zero});
        chk({tag, ".Overflow"}, {31'd0, bus.Overflow}, {31'd0, e.ovf});
    endtask

    // Drive one op; outputs must still show the previous result until the next edge.
    task automatic step(string tag, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        exp_t e;
        bus.op = op;
        bus.A  = a;
        bus.B  = b;
        #1;
        chk({tag, ".hold"}, bus.ALUOut, prev_exp.res);
        @(posedge clk);
        #1;
        e = model(op, a, b);
        check_all(tag, e);
        prev_exp = e;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] ops [6];
        ops[0] = 4'b0001;
        ops[1] = 4'b0010;
        ops[2] = 4'b0100;
        ops[3] = 4'b1000;
        ops[4] = 4'b0000;
        ops[5] = 4'($urandom);
        return ops[$urandom_range(0, 5)];
    endfunction

    exp_t reset_exp;

    initial begin
        total = 0;
        bad   = 0;
        reset_exp = '{res: 32'd0, neg: 1'b0, zero: 1'b1, ovf: 1'b0};

        // Reset held with a live op: reset must win.
        rst_n  = 1'b0;
        bus.op = 4'b0001;
        bus.A  = 32'h7FFF_FFFF;
        bus.B  = 32'h0000_0001;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", reset_exp);
        prev_exp = reset_exp;
        rst_n = 1'b1;

        step("add_1_1",   4'b0001, 32'h0000_0001, 32'h0000_0001);
        chk("add_1_1.lit", bus.ALUOut, 32'h0000_0002);
        step("sub_5_7",   4'b0010, 32'h0000_0005, 32'h0000_0007);
        chk("sub_5_7.lit", bus.ALUOut, 32'hFFFF_FFFE);
        step("sub_eq",    4'b0010, 32'h0000_1234, 32'h0000_1234);
        chk("sub_eq.zero", {31'd0, bus.Zero}, 32'd1);
        step("and",       4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("and.lit", bus.ALUOut, 32'hF000_F000);
        step("or",        4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("or.lit", bus.ALUOut, 32'hFFF0_FFF0);
        step("add_ovf",   4'b0001, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_ovf.lit", {bus.ALUOut[31:1], bus.Overflow}, {31'h4000_0000, 1'b1});
        step("sub_ovf",   4'b0010, 32'h8000_0000, 32'h0000_0001);
        chk("sub_ovf.lit", {bus.Overflow, bus.ALUOut[30:0]}, {1'b1, 31'h7FFF_FFFF});
        step("add_wrap",  4'b0001, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("add_wrap.lit", {29'd0, bus.Zero, bus.Overflow, bus.Neg}, {29'd0, 3'b100});
        step("illegal11", 4'b0011, 32'h1234_5678, 32'h0000_0001);
        step("illegal0",  4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("and_ovfm",  4'b0100, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), pick_op(), pick_operand(), pick_operand());
        end

        // Mid-stream reset for one edge.
        rst_n  = 1'b0;
        bus.op = 4'b1000;
        bus.A  = 32'hDEAD_BEEF;
        bus.B  = 32'h0000_0000;
        @(posedge clk);
        #1;
        check_all("reset_mid", reset_exp);
        prev_exp = reset_exp;
        rst_n = 1'b1;
        step("post_reset", 4'b0010, 32'h0000_0000, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
